// File: rtl/master_alu_datapath.sv
// master_alu_datapath: single-cycle execution core.
// Fetches RAM[pc] every clock, decodes it, reads two source registers,
// evaluates the ARM-style condition against NZCV, computes the ALU result,
// writes it back and advances the PC.
// Ports:
//   Clk, Reset           clock, asynchronous active-high reset
//   run                  1 = execute one instruction per cycle, 0 = hold
//   prog_we/addr/wdata   synchronous program RAM write port
//   dbg_sel / dbg_data   combinational register peek
//   pc, instruction      current PC and RAM[pc]
//   result               combinational ALU result of the current instruction
//   flags                registered {N,Z,C,V}
//   halted               set once a HALT executes, cleared only by Reset
module master_alu_datapath #(
  parameter int unsigned PROG_DEPTH = 256,
  parameter int unsigned NREGS      = 16,
  localparam int unsigned PC_W      = $clog2(PROG_DEPTH),
  localparam int unsigned RSEL_W    = $clog2(NREGS)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              run,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [31:0]       prog_wdata,
  input  logic [RSEL_W-1:0] dbg_sel,
  output logic [31:0]       dbg_data,
  output logic [PC_W-1:0]   pc,
  output logic [31:0]       instruction,
  output logic [31:0]       result,
  output logic [3:0]        flags,
  output logic              halted
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_ORR  = 4'h3;
  localparam logic [3:0] OP_EOR  = 4'h4;
  localparam logic [3:0] OP_MOV  = 4'h5;
  localparam logic [3:0] OP_MVN  = 4'h6;
  localparam logic [3:0] OP_LSL  = 4'h7;
  localparam logic [3:0] OP_LSR  = 4'h8;
  localparam logic [3:0] OP_ASR  = 4'h9;
  localparam logic [3:0] OP_ROR  = 4'hA;
  localparam logic [3:0] OP_CMP  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_ADC  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [31:0]     mem_q  [PROG_DEPTH];
  logic [31:0]     regs_q [NREGS];
  logic [31:0]     regs_d [NREGS];
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      flags_q, flags_d;
  logic            halted_q, halted_d;

  logic [3:0]  cond, opcode, dest, src1, src2;
  logic        s_bit;
  logic [4:0]  sh;
  logic [15:0] imm16;
  logic [31:0] op_a, op_b;
  logic        flag_n, flag_z, flag_c, flag_v;

  // Program RAM: no reset, fetch reads the pre-write contents
  always_ff @(posedge Clk) begin
    if (prog_we) begin
      mem_q[prog_addr] <= prog_wdata;
    end
  end

  assign instruction = mem_q[pc_q];

  // Instruction fields (imm16 overlaps src2/src1)
  assign cond   = instruction[31:28];
  assign opcode = instruction[27:24];
  assign s_bit  = instruction[23];
  assign dest   = instruction[22:19];
  assign src2   = instruction[18:15];
  assign src1   = instruction[14:11];
  assign sh     = instruction[10:6];
  assign imm16  = instruction[18:3];

  assign op_a = regs_q[src1];
  assign op_b = regs_q[src2];
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // Condition evaluation
  logic cond_pass;
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = ~flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = ~flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = ~flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = ~flag_v;
      4'h8: cond_pass = flag_c & ~flag_z;
      4'h9: cond_pass = ~flag_c | flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = ~flag_z & (flag_n == flag_v);
      4'hD: cond_pass = flag_z | (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Wide intermediates: the extra bit carries C out of adders and shifters
  logic [32:0] add_w, sub_w, lsl_w, lsr_w, asr_w;
  logic [31:0] ror_w;
  logic        add_v, sub_v;

  assign add_w = {1'b0, op_a} + {1'b0, op_b} + {32'd0, (opcode == OP_ADC) & flag_c};
  assign sub_w = {1'b0, op_a} - {1'b0, op_b};
  assign lsl_w = {1'b0, op_a} << sh;
  assign lsr_w = {op_a, 1'b0} >> sh;
  assign asr_w = $signed({op_a, 1'b0}) >>> sh;
  assign ror_w = (op_a >> sh) | (op_a << (6'd32 - {1'b0, sh}));
  assign add_v = (op_a[31] == op_b[31]) && (add_w[31] != op_a[31]);
  assign sub_v = (op_a[31] != op_b[31]) && (sub_w[31] != op_a[31]);

  // ALU result and candidate C/V (unchanged unless the op defines them)
  logic [31:0] alu_res;
  logic        c_new, v_new;
  always_comb begin
    alu_res = 32'd0;
    c_new   = flag_c;
    v_new   = flag_v;
    case (opcode)
      OP_ADD, OP_ADC: begin
        alu_res = add_w[31:0];
        c_new   = add_w[32];
        v_new   = add_v;
      end
      OP_SUB, OP_CMP: begin
        alu_res = sub_w[31:0];
        c_new   = ~sub_w[32];
        v_new   = sub_v;
      end
      OP_AND: alu_res = op_a & op_b;
      OP_ORR: alu_res = op_a | op_b;
      OP_EOR: alu_res = op_a ^ op_b;
      OP_MOV: alu_res = {16'd0, imm16};
      OP_MVN: alu_res = ~op_a;
      OP_MUL: alu_res = op_a * op_b;
      OP_LSL: begin
        alu_res = lsl_w[31:0];
        if (sh != 5'd0) c_new = lsl_w[32];
      end
      OP_LSR: begin
        alu_res = lsr_w[32:1];
        if (sh != 5'd0) c_new = lsr_w[0];
      end
      OP_ASR: begin
        alu_res = asr_w[32:1];
        if (sh != 5'd0) c_new = asr_w[0];
      end
      OP_ROR: begin
        alu_res = ror_w;
        if (sh != 5'd0) c_new = ror_w[31];
      end
      default: alu_res = 32'd0;
    endcase
  end

  logic wr_op, flag_op, exec_en;
  assign wr_op   = (opcode <= OP_ROR) || (opcode == OP_MUL) || (opcode == OP_ADC);
  assign flag_op = (opcode == OP_CMP) || (s_bit && (opcode <= OP_ADC));
  assign exec_en = run & ~halted_q;

  // Next architectural state
  always_comb begin
    pc_d     = pc_q;
    regs_d   = regs_q;
    flags_d  = flags_q;
    halted_d = halted_q;
    if (exec_en) begin
      if (cond_pass && (opcode == OP_HALT)) begin
        halted_d = 1'b1;
      end else begin
        pc_d = pc_q + PC_W'(1);
        if (cond_pass && wr_op) begin
          regs_d[dest] = alu_res;
        end
        if (cond_pass && flag_op) begin
          flags_d = {alu_res[31], (alu_res == 32'd0), c_new, v_new};
        end
      end
    end
  end

  // State registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q     <= '0;
      flags_q  <= '0;
      halted_q <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      flags_q  <= flags_d;
      halted_q <= halted_d;
      regs_q   <= regs_d;
    end
  end

  assign pc       = pc_q;
  assign flags    = flags_q;
  assign halted   = halted_q;
  assign result   = alu_res;
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: tb/tb_master_alu_datapath.sv
// Testbench for master_alu_datapath: per-cycle scoreboard against an
// arithmetic reference model, directed programs plus random programs.
module tb_master_alu_datapath;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        run = 1'b0;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = 8'd0;
  logic [31:0] prog_wdata = 32'd0;
  logic [3:0]  dbg_sel = 4'd0;
  logic [31:0] dbg_data, instruction, result;
  logic [7:0]  pc;
  logic [3:0]  flags;
  logic        halted;

  master_alu_datapath dut (
    .Clk(Clk), .Reset(Reset), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .dbg_sel(dbg_sel),
    .dbg_data(dbg_data), .pc(pc), .instruction(instruction),
    .result(result), .flags(flags), .halted(halted)
  );

  always #5 Clk = ~Clk;

  localparam logic [31:0] NOP  = 32'hEE000000;
  localparam logic [31:0] HALT = 32'hEF000000;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] ins;
    bit          ins_known;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        halted;
    logic [31:0] dbg;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;

  // Reference model state
  logic [31:0] m_mem [256];
  bit          m_known [256];
  logic [31:0] m_r [16];
  logic [3:0]  m_flags = 4'd0;
  logic [7:0]  m_pc = 8'd0;
  bit          m_halted = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] enc(input logic [3:0] cnd, input logic [3:0] op, input logic s,
                                      input logic [3:0] rd, input logic [3:0] rs2,
                                      input logic [3:0] rs1, input logic [4:0] sh);
    return {cnd, op, s, rd, rs2, rs1, sh, 6'd0};
  endfunction

  function automatic logic [31:0] mov(input logic [3:0] rd, input logic [15:0] imm);
    return {4'hE, 4'h5, 1'b0, rd, imm, 3'd0};
  endfunction

  function automatic logic [31:0] rnd_ins();
    logic [3:0] cnd, op;
    cnd = ($urandom_range(0, 1) != 0) ? 4'hE : 4'($urandom_range(0, 15));
    op  = ($urandom_range(0, 199) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    return {cnd, op, 24'($urandom)};
  endfunction

  function automatic bit m_cond(input logic [3:0] cnd, input logic [3:0] f);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (cnd)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Behavioural evaluation of one instruction against current model state
  task automatic m_eval(input logic [31:0] ins, output logic [31:0] res, output bit pass,
                        output bit wr, output bit upd, output logic [3:0] nf);
    logic [3:0]  op;
    logic [31:0] a, b;
    int unsigned sh;
    longint      ws, ss;
    bit          n, z, c, v;
    op = ins[27:24];
    a  = m_r[ins[14:11]];
    b  = m_r[ins[18:15]];
    sh = ins[10:6];
    {n, z, c, v} = m_flags;
    res = 32'd0;
    case (op)
      4'h0, 4'hD: begin
        ws = longint'(a) + longint'(b) + ((op == 4'hD) ? longint'(c) : 64'sd0);
        ss = longint'($signed(a)) + longint'($signed(b)) + ((op == 4'hD) ? longint'(c) : 64'sd0);
        res = ws[31:0];
        c = ws[32];
        v = (ss > MAXI) || (ss < MINI);
      end
      4'h1, 4'hB: begin
        ss = longint'($signed(a)) - longint'($signed(b));
        res = a - b;
        c = (a >= b);
        v = (ss > MAXI) || (ss < MINI);
      end
      4'h2: res = a & b;
      4'h3: res = a | b;
      4'h4: res = a ^ b;
      4'h5: res = {16'd0, ins[18:3]};
      4'h6: res = ~a;
      4'h7: begin res = a << sh; if (sh != 0) c = a[32-sh]; end
      4'h8: begin res = a >> sh; if (sh != 0) c = a[sh-1]; end
      4'h9: begin res = $unsigned($signed(a) >>> sh); if (sh != 0) c = a[sh-1]; end
      4'hA: begin
        res = a;
        for (int k = 0; k < int'(sh); k++) res = {res[0], res[31:1]};
        if (sh != 0) c = res[31];
      end
      4'hC: res = a * b;
      default: res = 32'd0;
    endcase
    pass = m_cond(ins[31:28], m_flags);
    wr   = pass && ((op <= 4'hA) || (op == 4'hC) || (op == 4'hD));
    upd  = pass && ((op == 4'hB) || (ins[23] && (op <= 4'hD)));
    nf   = {res[31], (res == 32'd0), c, v};
  endtask

  task automatic push_exp();
    exp_t e;
    logic [31:0] res;
    bit pass, wr, upd;
    logic [3:0] nf;
    e.pc = m_pc;
    e.ins = m_mem[m_pc];
    e.ins_known = m_known[m_pc];
    m_eval(e.ins, res, pass, wr, upd, nf);
    e.res = res;
    e.flags = m_flags;
    e.halted = m_halted;
    e.dbg = m_r[dbg_sel];
    sb.push_back(e);
  endtask

  // One clock: drive inputs, push expectation, advance model across the edge
  task automatic cycle(input bit r, input int sel = -1, input bit we = 1'b0,
                       input logic [7:0] wa = 8'd0, input logic [31:0] wd = 32'd0);
    logic [31:0] ins, res;
    bit pass, wr, upd;
    logic [3:0] nf;
    run = r;
    prog_we = we;
    prog_addr = wa;
    prog_wdata = wd;
    dbg_sel = (sel < 0) ? 4'($urandom_range(0, 15)) : 4'(sel);
    push_exp();
    if (r && !m_halted) begin
      ins = m_mem[m_pc];
      m_eval(ins, res, pass, wr, upd, nf);
      if (pass && (ins[27:24] == 4'hF)) begin
        m_halted = 1'b1;
      end else begin
        m_pc = m_pc + 8'd1;
        if (wr) m_r[ins[22:19]] = res;
        if (upd) m_flags = nf;
      end
    end
    if (we) begin
      m_mem[wa] = wd;
      m_known[wa] = 1'b1;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic run_n(input int n);
    repeat (n) cycle(1'b1);
  endtask

  task automatic expect_reg(input int sel, input logic [31:0] val, input string name);
    cycle(1'b0, sel);
    chk(name, dbg_data, val);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before the next edge
  task automatic do_reset();
    Reset = 1'b1;
    run = 1'b0;
    prog_we = 1'b0;
    dbg_sel = 4'd3;
    m_pc = 8'd0;
    m_flags = 4'd0;
    m_halted = 1'b0;
    for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
    #1;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_r3", dbg_data, 32'd0);
    push_exp();
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle
  always @(negedge Clk) begin
    if (mon_on) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_empty: got no expectation expected one (t=%0t)", $time);
      end else begin
        e_mon = sb.pop_front();
        chk("pc", 32'(pc), 32'(e_mon.pc));
        if (e_mon.ins_known) begin
          chk("instruction", instruction, e_mon.ins);
          chk("result", result, e_mon.res);
        end
        chk("flags", 32'(flags), 32'(e_mon.flags));
        chk("halted", 32'(halted), 32'(e_mon.halted));
        chk("dbg_data", dbg_data, e_mon.dbg);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] p2 [17];
  logic [31:0] p3 [6];

  initial begin
    for (int i = 0; i < 256; i++) begin m_mem[i] = 32'd0; m_known[i] = 1'b0; end
    for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
    p3[0] = 32'hE5080028; p3[1] = 32'hE5100018; p3[2] = 32'hE0990800;
    p3[3] = NOP;          p3[4] = HALT;          p3[5] = mov(4'd1, 16'd9);
    p2[0]  = mov(4'd4, 16'd1);
    p2[1]  = enc(4'hE, 4'h7, 1'b0, 4'd6, 4'd0, 4'd4, 5'd31);
    p2[2]  = enc(4'hE, 4'h6, 1'b0, 4'd1, 4'd0, 4'd6, 5'd0);
    p2[3]  = mov(4'd2, 16'd1);
    p2[4]  = enc(4'hE, 4'h0, 1'b1, 4'd3, 4'd2, 4'd1, 5'd0);
    p2[5]  = mov(4'd7, 16'd5);
    p2[6]  = mov(4'd8, 16'd5);
    p2[7]  = enc(4'hE, 4'hB, 1'b0, 4'd9, 4'd8, 4'd7, 5'd0);
    p2[8]  = enc(4'h1, 4'h0, 1'b0, 4'd10, 4'd8, 4'd7, 5'd0);
    p2[9]  = enc(4'h0, 4'h0, 1'b0, 4'd10, 4'd8, 4'd7, 5'd0);
    p2[10] = mov(4'd11, 16'h8000);
    p2[11] = enc(4'hE, 4'h7, 1'b0, 4'd11, 4'd0, 4'd11, 5'd16);
    p2[12] = mov(4'd12, 16'd1);
    p2[13] = enc(4'hE, 4'h3, 1'b0, 4'd13, 4'd12, 4'd11, 5'd0);
    p2[14] = enc(4'hE, 4'h8, 1'b1, 4'd14, 4'd0, 4'd13, 5'd1);
    p2[15] = enc(4'hE, 4'h9, 1'b0, 4'd15, 4'd0, 4'd13, 5'd1);
    p2[16] = enc(4'hE, 4'hA, 1'b0, 4'd5, 4'd0, 4'd13, 5'd1);

    @(posedge Clk);
    #1;
    Reset = 1'b0;
    mon_on = 1'b1;

    for (int i = 0; i < 256; i++) cycle(1'b0, -1, 1'b1, 8'(i), NOP);

    // Basic program, then HALT at address 4
    for (int i = 0; i < 6; i++) cycle(1'b0, -1, 1'b1, 8'(i), p3[i]);
    do_reset();
    run_n(3);
    chk("basic_pc", 32'(pc), 32'd3);
    chk("basic_flags", 32'(flags), 32'd0);
    expect_reg(1, 32'd5, "basic_r1");
    expect_reg(2, 32'd3, "basic_r2");
    expect_reg(3, 32'd8, "basic_r3");
    run_n(12);
    chk("halt_pc", 32'(pc), 32'd4);
    chk("halt_flag", 32'(halted), 32'd1);
    expect_reg(1, 32'd5, "halt_r1_frozen");
    expect_reg(3, 32'd8, "halt_r3_frozen");

    // Overflow, CMP, conditional writes, shifts
    for (int i = 0; i < 17; i++) cycle(1'b0, -1, 1'b1, 8'(i), p2[i]);
    do_reset();
    run_n(4);
    chk("adds_ovf_result", result, 32'h80000000);
    run_n(1);
    chk("adds_ovf_flags", 32'(flags), 32'b1001);
    expect_reg(3, 32'h80000000, "adds_ovf_r3");
    run_n(3);
    chk("cmp_flags", 32'(flags), 32'b0110);
    expect_reg(9, 32'd0, "cmp_no_write");
    run_n(1);
    chk("ne_fail_pc", 32'(pc), 32'd9);
    expect_reg(10, 32'd0, "ne_fail_r10");
    run_n(1);
    expect_reg(10, 32'd10, "eq_pass_r10");
    run_n(7);
    expect_reg(13, 32'h80000001, "orr_r13");
    expect_reg(14, 32'h40000000, "lsr_r14");
    expect_reg(15, 32'hC0000000, "asr_r15");
    expect_reg(5, 32'hC0000000, "ror_r5");
    chk("lsrs_flags", 32'(flags), 32'b0010);

    // Reset in the middle of a run: RAM kept, execution restarts at 0
    run_n(2);
    do_reset();
    chk("rst_ram_kept", instruction, p2[0]);
    run_n(1);
    expect_reg(4, 32'd1, "restart_r4");
    chk("restart_pc", 32'(pc), 32'd1);

    // PC wrap, plus a write to the address being fetched
    for (int i = 0; i < 17; i++) cycle(1'b0, -1, 1'b1, 8'(i), NOP);
    do_reset();
    cycle(1'b1, -1, 1'b1, 8'd0, mov(4'd2, 16'd7));
    run_n(254);
    chk("wrap_pc255", 32'(pc), 32'd255);
    expect_reg(2, 32'd0, "fetch_old_word");
    run_n(1);
    chk("wrap_pc0", 32'(pc), 32'd0);
    run_n(1);
    expect_reg(2, 32'd7, "fetch_new_word");
    chk("wrap_pc1", 32'(pc), 32'd1);

    // Random programs with random run gaps and writes while running
    for (int i = 0; i < 256; i++) cycle(1'b0, -1, 1'b1, 8'(i), rnd_ins());
    repeat (4) begin
      do_reset();
      repeat (250) begin
        cycle(($urandom_range(0, 9) != 0), -1, ($urandom_range(0, 19) == 0),
              8'($urandom_range(0, 255)), rnd_ins());
      end
    end

    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/master_alu_datapath.md
Name: master_alu_datapath

Overview:
Single-cycle execution core that combines a 256x32 program RAM, a 16x32 register bank and a conditional ALU with NZCV flags. Each clock it fetches the word at the program counter, decodes it, and reads two source registers. It evaluates the condition against the flags, computes the ALU result, writes the result back and advances the PC. It sits under the CPU top level; memory-access instructions (LDR/STR) are handled outside this block.

Parameters:
PROG_DEPTH, 256, program RAM words; PC is log2(PROG_DEPTH) bits wide and wraps.
NREGS, 16, general registers r0..r15; all are ordinary registers, none is aliased to the PC.

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Reset  input  1  asynchronous, active-high reset.
run  input  1  1 = execute one instruction per cycle; 0 = PC, registers and flags hold.
prog_we  input  1  program RAM write strobe, synchronous.
prog_addr  input  8  program RAM write address.
prog_wdata  input  32  program RAM write data.
dbg_sel  input  4  selects the register shown on dbg_data.
dbg_data  output  32  combinational R[dbg_sel].
pc  output  8  current program counter.
instruction  output  32  RAM[pc], combinational read.
result  output  32  ALU result of the current instruction.
flags  output  4  registered {N,Z,C,V}.
halted  output  1  set once a HALT instruction executes.

Behaviour:
- Reset (async): pc=0, r0..r15=0, flags=0, halted=0. RAM contents are not affected.
- Instruction fields:
  - Cond[31:28], OpCode[27:24], S[23], dest[22:19], src2[18:15], src1[14:11].
  - sh[10:6]: shift amount.
  - imm16[18:3]: MOV immediate; it overlaps src2/src1.
- Operands: A=R[src1], B=R[src2], both read combinationally.
- Condition codes (ARM): 0 EQ, 1 NE, 2 CS, 3 CC, 4 MI, 5 PL, 6 VS, 7 VC, 8 HI, 9 LS, A GE, B LT, C GT, D LE, E AL, F NV.
- A failed condition writes nothing and changes no flags; the PC still advances.
- Opcodes:
  - 0 ADD A+B; 1 SUB A-B; 2 AND; 3 ORR; 4 EOR.
  - 5 MOV: dest = zero-extended imm16.
  - 6 MVN: ~A.
  - 7 LSL A<<sh; 8 LSR A>>sh; 9 ASR (arithmetic A>>sh); A ROR A by sh.
  - B CMP: A-B, no register write.
  - C MUL: low 32 bits of A*B.
  - D ADC: A+B+C.
  - E NOP.
  - F HALT.
- Flags update only when S=1 and the condition passes; CMP always updates flags when its condition passes.
  - N = result[31], Z = (result==0).
  - ADD/ADC: C = carry out of bit 31; V = signed overflow.
  - SUB/CMP: C = NOT borrow (A>=B unsigned); V = signed overflow.
  - Shifts/ROR: C = last bit shifted out; sh=0 leaves C unchanged. V unchanged.
  - AND/ORR/EOR/MOV/MVN/MUL: C and V unchanged.
- Register writeback at the rising edge when run=1, !halted, the condition passes and the opcode is one of 0-A, C or D.
- PC: pc <= pc+1 (mod 256) each enabled cycle, including NOP and failed-condition instructions.
- HALT (condition passes): halted<=1 and pc holds; the block then stays halted until Reset.
- RAM write: RAM[prog_addr] <= prog_wdata at the rising edge. The fetch in the same cycle sees the old contents, and writes are allowed while running.
- result is driven combinationally for every opcode: 0 for NOP/HALT, the computed value for CMP.

Test Plan:
- Reset mid-run, after r3 and flags are nonzero -> pc, all regs, flags and halted read 0 immediately, before the next clock edge; RAM is preserved and execution restarts at address 0.
- Load 0xE5080028 (MOV r1,#5), 0xE5100018 (MOV r2,#3), 0xE0990800 (ADDS r3,r1,r2), then run=1 -> r1=5, r2=3, r3=8, flags=0000, pc=3 after 3 cycles.
- With r1=0x7FFFFFFF and r2=1, ADDS -> result 0x80000000, N=1, V=1, C=0, Z=0. With r1=5 and r2=5, CMP -> Z=1, C=1 and no register written.
- After a CMP giving Z=1: a conditional write with Cond=1 (NE) leaves dest unchanged and the PC still advances; the same instruction with Cond=0 (EQ) writes dest.
- With r1=0x80000001 and sh=1: LSR -> 0x40000000 (C=1 if S=1); ASR -> 0xC0000000; ROR -> 0xC0000000.
- Place HALT at address 4 -> pc stays 4, halted=1, registers frozen over 10 further cycles. Separately, a program running to address 255 wraps the PC to 0.
